// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the RV32I decode / ID-stage control slice.
//
// Contents:
//   - RV32I major opcode constants and the M-extension funct7 marker
//   - encodings for operand-B select, ALU control and unconditional-branch kind
//   - ctrl_bundle_t: everything the ID/EX control register carries
//   - CTRL_BUBBLE: the all-zero bundle used for bubbles and reset
//   - md_state_e: states of the multi-cycle M-op sequencer
//   - uses_rs1 / uses_rs2: which opcodes actually read a source register
//
// Build option: RV32M_EXT_EN (consumed by ctrl_decode and id_ctrl_stage).
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 value that turns an R-type encoding into MUL/DIV/REM
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    OPB_RS2  = 2'b00,
    OPB_IMM  = 2'b01,
    OPB_FOUR = 2'b10
  } op_b_sel_e;

  typedef enum logic [1:0] {
    ALU_FUNCT = 2'b00,
    ALU_ADD   = 2'b01,
    ALU_PASS  = 2'b10
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    UNCBR_NONE = 2'b00,
    UNCBR_JAL  = 2'b10,
    UNCBR_JALR = 2'b11
  } uncbr_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic      ctrl_vld;
    logic      op_a_sel;
    op_b_sel_e op_b_sel;
    alu_ctrl_e alu_ctrl;
    logic      is_br;
    uncbr_e    is_uncbr;
    logic      mem_wren;
    logic      mem_rden;
    logic      rd_wren;
    logic      wb_sel;
    logic [4:0] rd_addr;
    logic      md_vld;
    logic [2:0] md_op;
    logic      illegal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  // Opcodes whose rs1 field names a real source operand
  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OPC_R, OPC_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Opcodes whose rs2 field names a real source operand
  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OPC_R, OPC_STORE, OPC_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- purely combinational RV32I(+M) control decode.
//
// Ports:
//   instr_i     in  32  instruction word from IF/ID
//   ctrl_o      out     decoded control bundle (ctrl_vld always 1; the stage
//                       decides whether it is actually latched)
//   rs1_addr_o  out  5  rs1 field
//   rs2_addr_o  out  5  rs2 field
//   rs1_used_o  out  1  this opcode reads rs1
//   rs2_used_o  out  1  this opcode reads rs2
//
// Build option: RV32M_EXT_EN -- when defined, R-type with funct7=0000001
// decodes as an M op; otherwise that encoding is reported illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr_i,
  output ctrl_bundle_t ctrl_o,
  output logic [4:0]   rs1_addr_o,
  output logic [4:0]   rs2_addr_o,
  output logic         rs1_used_o,
  output logic         rs2_used_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd_field;

  assign opcode   = instr_i[6:0];
  assign rd_field = instr_i[11:7];
  assign funct3   = instr_i[14:12];
  assign funct7   = instr_i[31:25];

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];
  assign rs1_used_o = uses_rs1(opcode);
  assign rs2_used_o = uses_rs2(opcode);

`ifndef RV32M_EXT_EN
  // funct3 only steers M ops, which do not exist in this build
  logic unused_funct3;
  assign unused_funct3 = ^funct3;
`endif

  // Opcode table. Everything starts from the bubble so unlisted fields stay 0;
  // the destination address is filled in last so it is 0 whenever nothing
  // will be written back.
  always_comb begin
    ctrl_o          = CTRL_BUBBLE;
    ctrl_o.ctrl_vld = 1'b1;
    case (opcode)
      OPC_R: begin
        if (funct7 == FUNCT7_MULDIV) begin
`ifdef RV32M_EXT_EN
          ctrl_o.rd_wren = 1'b1;
          ctrl_o.md_vld  = 1'b1;
          ctrl_o.md_op   = funct3;
`else
          ctrl_o.illegal = 1'b1;
`endif
        end else begin
          ctrl_o.rd_wren = 1'b1;
        end
      end
      OPC_IMM: begin
        ctrl_o.op_b_sel = OPB_IMM;
        ctrl_o.rd_wren  = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.op_b_sel = OPB_IMM;
        ctrl_o.alu_ctrl = ALU_ADD;
        ctrl_o.mem_rden = 1'b1;
        ctrl_o.wb_sel   = 1'b1;
        ctrl_o.rd_wren  = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.op_b_sel = OPB_IMM;
        ctrl_o.alu_ctrl = ALU_ADD;
        ctrl_o.mem_wren = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.is_br = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.op_b_sel = OPB_FOUR;
        ctrl_o.alu_ctrl = ALU_PASS;
        ctrl_o.is_uncbr = UNCBR_JAL;
        ctrl_o.rd_wren  = 1'b1;
      end
      OPC_JALR: begin
        ctrl_o.op_b_sel = OPB_FOUR;
        ctrl_o.alu_ctrl = ALU_PASS;
        ctrl_o.is_uncbr = UNCBR_JALR;
        ctrl_o.rd_wren  = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.op_b_sel = OPB_IMM;
        ctrl_o.alu_ctrl = ALU_PASS;
        ctrl_o.rd_wren  = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_o.op_a_sel = 1'b1;
        ctrl_o.op_b_sel = OPB_IMM;
        ctrl_o.rd_wren  = 1'b1;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
    ctrl_o.rd_addr = ctrl_o.rd_wren ? rd_field : 5'd0;
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage -- registered ID-stage control: decode, load-use bubbles and
// multi-cycle M-op sequencing, feeding the ID/EX control register.
//
// Parameters:
//   MUL_LAT  EX cycles for MUL/MULH/MULHSU/MULHU (>=1)
//   DIV_LAT  EX cycles for DIV/DIVU/REM/REMU (>=1)
//   The busy-counter width is derived internally from the larger latency.
//
// Ports:
//   clk_i, rst_i      clock; synchronous active-high reset
//   instr_i           instruction from IF/ID
//   instr_vld_i       IF/ID holds a valid instruction
//   flush_i           redirect; kill the ID/EX contents
//   op_a_sel_o .. illegal_o   registered ID/EX control bundle
//   ctrl_vld_o        ID/EX slot holds a real instruction (0 = bubble)
//   stall_o           hold PC and IF/ID (combinational)
//
// Build option: RV32M_EXT_EN -- enables M-op decode and the IDLE/BUSY
// sequencer. Without it stall_o comes from load-use hazards alone.
module id_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        instr_vld_i,
  input  logic        flush_i,
  output logic        op_a_sel_o,
  output logic [1:0]  op_b_sel_o,
  output logic [1:0]  alu_ctrl_o,
  output logic        is_br_o,
  output logic [1:0]  is_uncbr_o,
  output logic        mem_wren_o,
  output logic        mem_rden_o,
  output logic        rd_wren_o,
  output logic        wb_sel_o,
  output logic [4:0]  rd_addr_o,
  output logic        ctrl_vld_o,
  output logic        md_vld_o,
  output logic [2:0]  md_op_o,
  output logic        illegal_o,
  output logic        stall_o
);

  ctrl_bundle_t dec;
  ctrl_bundle_t idex_q;
  logic [4:0]   dec_rs1;
  logic [4:0]   dec_rs2;
  logic         dec_rs1_used;
  logic         dec_rs2_used;
  logic         load_use;
  logic         busy;

  ctrl_decode u_decode (
    .instr_i    (instr_i),
    .ctrl_o     (dec),
    .rs1_addr_o (dec_rs1),
    .rs2_addr_o (dec_rs2),
    .rs1_used_o (dec_rs1_used),
    .rs2_used_o (dec_rs2_used)
  );

  // A load sitting in ID/EX whose destination feeds the instruction now in
  // IF/ID cannot forward in time, so that instruction must wait one cycle.
  // Writes to x0 never create a dependency.
  logic rs1_hit;
  logic rs2_hit;
  assign rs1_hit  = dec_rs1_used && (dec_rs1 == idex_q.rd_addr);
  assign rs2_hit  = dec_rs2_used && (dec_rs2 == idex_q.rd_addr);
  assign load_use = idex_q.ctrl_vld && idex_q.mem_rden && (idex_q.rd_addr != 5'd0)
                    && instr_vld_i && (rs1_hit || rs2_hit);

`ifdef RV32M_EXT_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] lat_m1;
  logic             take_decode;

  // funct3[2] separates the divide family from the multiply family
  assign lat_m1      = dec.md_op[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  assign take_decode = !load_use && instr_vld_i;
  assign busy        = (state_q == BUSY);

  // Sequencer state and remaining-cycle counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The op stays in ID/EX for LAT cycles in total: the latch edge starts
  // BUSY with LAT-1 remaining, and the edge that sees 1 returns to IDLE
  // while the register is still held, so the op gets one final IDLE cycle
  // and the next instruction is latched straight after it. Single-cycle
  // ops load 0 and never leave IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (take_decode && dec.md_vld && (lat_m1 != '0)) begin
      state_d = BUSY;
      cnt_d   = lat_m1;
    end
  end
`else
  // Latencies are only meaningful when the M extension is built in
  logic [31:0] unused_lat;
  assign unused_lat = MUL_LAT + DIV_LAT;
  assign busy       = 1'b0;
`endif

  // ID/EX control register. Flush beats everything but reset; while an
  // M op is running the register is frozen, which also makes any hazard
  // check against the held instruction irrelevant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q <= CTRL_BUBBLE;
    end else if (flush_i) begin
      idex_q <= CTRL_BUBBLE;
    end else if (busy) begin
      idex_q <= idex_q;
    end else if (load_use) begin
      idex_q <= CTRL_BUBBLE;
    end else if (instr_vld_i) begin
      idex_q <= dec;
    end else begin
      idex_q <= CTRL_BUBBLE;
    end
  end

  assign stall_o = load_use || busy;

  assign op_a_sel_o = idex_q.op_a_sel;
  assign op_b_sel_o = idex_q.op_b_sel;
  assign alu_ctrl_o = idex_q.alu_ctrl;
  assign is_br_o    = idex_q.is_br;
  assign is_uncbr_o = idex_q.is_uncbr;
  assign mem_wren_o = idex_q.mem_wren;
  assign mem_rden_o = idex_q.mem_rden;
  assign rd_wren_o  = idex_q.rd_wren;
  assign wb_sel_o   = idex_q.wb_sel;
  assign rd_addr_o  = idex_q.rd_addr;
  assign ctrl_vld_o = idex_q.ctrl_vld;
  assign md_vld_o   = idex_q.md_vld;
  assign md_op_o    = idex_q.md_op;
  assign illegal_o  = idex_q.illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb_id_ctrl_stage -- self-checking bench for id_ctrl_stage.
// Directed scenarios followed by randomized traffic, all compared against a
// cycle-level reference model (expected ID/EX contents + remaining busy cycles).
// Honors RV32M_EXT_EN the same way the design does.
module tb_id_ctrl_stage;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  localparam logic [31:0] I_ADD3  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD6  = 32'h00128333; // add  x6,x5,x1
  localparam logic [31:0] I_MUL7  = 32'h022083B3; // mul  x7,x1,x2
  localparam logic [31:0] I_DIV8  = 32'h0220C433; // div  x8,x1,x2
  localparam logic [31:0] I_NOP   = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_ADDI9 = 32'h00100493; // addi x9,x0,1
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        instr_vld_i;
  logic        flush_i;
  logic        op_a_sel_o;
  logic [1:0]  op_b_sel_o;
  logic [1:0]  alu_ctrl_o;
  logic        is_br_o;
  logic [1:0]  is_uncbr_o;
  logic        mem_wren_o;
  logic        mem_rden_o;
  logic        rd_wren_o;
  logic        wb_sel_o;
  logic [4:0]  rd_addr_o;
  logic        ctrl_vld_o;
  logic        md_vld_o;
  logic [2:0]  md_op_o;
  logic        illegal_o;
  logic        stall_o;

  id_ctrl_stage #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .instr_i     (instr_i),
    .instr_vld_i (instr_vld_i),
    .flush_i     (flush_i),
    .op_a_sel_o  (op_a_sel_o),
    .op_b_sel_o  (op_b_sel_o),
    .alu_ctrl_o  (alu_ctrl_o),
    .is_br_o     (is_br_o),
    .is_uncbr_o  (is_uncbr_o),
    .mem_wren_o  (mem_wren_o),
    .mem_rden_o  (mem_rden_o),
    .rd_wren_o   (rd_wren_o),
    .wb_sel_o    (wb_sel_o),
    .rd_addr_o   (rd_addr_o),
    .ctrl_vld_o  (ctrl_vld_o),
    .md_vld_o    (md_vld_o),
    .md_op_o     (md_op_o),
    .illegal_o   (illegal_o),
    .stall_o     (stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected ID/EX contents, in the same order as obs_bundle below
  typedef struct packed {
    logic       vld;
    logic       op_a;
    logic [1:0] op_b;
    logic [1:0] alu;
    logic       br;
    logic [1:0] unc;
    logic       mw;
    logic       mr;
    logic       rw;
    logic       wb;
    logic [4:0] rd;
    logic       mdv;
    logic [2:0] mdop;
    logic       ill;
  } exp_t;

  logic [22:0] obs_bundle;
  assign obs_bundle = {ctrl_vld_o, op_a_sel_o, op_b_sel_o, alu_ctrl_o, is_br_o, is_uncbr_o,
                       mem_wren_o, mem_rden_o, rd_wren_o, wb_sel_o, rd_addr_o,
                       md_vld_o, md_op_o, illegal_o};

  exp_t exp_q;
  int   busy_left;
  logic model_stall;
  int   checks_total;
  int   checks_passed;

  // Reference decode straight from the opcode table
  function automatic exp_t model_decode(input logic [31:0] ins);
    exp_t e;
    e = '0;
    e.vld = 1'b1;
    case (ins[6:0])
      7'h33: begin
        if (ins[31:25] == 7'h01) begin
`ifdef RV32M_EXT_EN
          e.rw = 1'b1; e.mdv = 1'b1; e.mdop = ins[14:12];
`else
          e.ill = 1'b1;
`endif
        end else e.rw = 1'b1;
      end
      7'h13: begin e.op_b = 2'd1; e.rw = 1'b1; end
      7'h03: begin e.op_b = 2'd1; e.alu = 2'd1; e.mr = 1'b1; e.wb = 1'b1; e.rw = 1'b1; end
      7'h23: begin e.op_b = 2'd1; e.alu = 2'd1; e.mw = 1'b1; end
      7'h63: e.br = 1'b1;
      7'h6F: begin e.op_b = 2'd2; e.alu = 2'd2; e.unc = 2'd2; e.rw = 1'b1; end
      7'h67: begin e.op_b = 2'd2; e.alu = 2'd2; e.unc = 2'd3; e.rw = 1'b1; end
      7'h37: begin e.op_b = 2'd1; e.alu = 2'd2; e.rw = 1'b1; end
      7'h17: begin e.op_a = 1'b1; e.op_b = 2'd1; e.rw = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.rw) e.rd = ins[11:7];
    return e;
  endfunction

  function automatic logic model_load_use(input logic [31:0] ins, input logic vld);
    logic r1;
    logic r2;
    r1 = ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63};
    r2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
    return exp_q.vld && exp_q.mr && (exp_q.rd != 5'd0) && vld &&
           ((r1 && ins[19:15] == exp_q.rd) || (r2 && ins[24:20] == exp_q.rd));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    w[19:15] = 5'($urandom_range(0, 6));
    w[24:20] = 5'($urandom_range(0, 6));
    w[11:7]  = 5'($urandom_range(0, 6));
    case ($urandom_range(0, 13))
      0:  begin w[6:0] = 7'h33; w[31:25] = 7'h00; end
      1:  begin w[6:0] = 7'h33; w[31:25] = 7'h20; end
      2:  begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
      3:  w[6:0] = 7'h13;
      4:  w[6:0] = 7'h03;
      5:  w[6:0] = 7'h03;
      6:  w[6:0] = 7'h23;
      7:  w[6:0] = 7'h63;
      8:  w[6:0] = 7'h6F;
      9:  w[6:0] = 7'h67;
      10: w[6:0] = 7'h37;
      11: w[6:0] = 7'h17;
      12: w[6:0] = 7'h7F;
      default: ;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_total++;
    if (got === want) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
  endtask

  // One cycle: drive inputs after the falling edge, check the model, then
  // advance the model to what the coming rising edge should produce.
  task automatic applyStimulus(input logic rst, input logic [31:0] ins,
                               input logic vld, input logic fl);
    logic lu;
    @(negedge clk_i);
    rst_i = rst; instr_i = ins; instr_vld_i = vld; flush_i = fl;
    #1;
    lu = model_load_use(ins, vld);
    model_stall = lu || (busy_left > 0);
    checkOutput("bundle", {9'd0, obs_bundle}, {9'd0, exp_q});
    checkOutput("stall", {31'd0, stall_o}, {31'd0, model_stall});
    if (rst || fl) begin
      exp_q = '0; busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (lu || !vld) begin
      exp_q = '0;
    end else begin
      exp_q = model_decode(ins);
      if (exp_q.mdv) busy_left = (exp_q.mdop[2] ? DIV_LAT : MUL_LAT) - 1;
    end
  endtask

  logic [31:0] rnd_ins;
  logic        rnd_vld;
  logic        rnd_rst;
  logic        rnd_fl;
  int          stall_cnt;

  initial begin
    checks_total = 0; checks_passed = 0;
    rst_i = 1'b1; instr_i = '0; instr_vld_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    exp_q = '0; busy_left = 0; model_stall = 1'b0;

    // reset state, then a plain add
    applyStimulus(1'b0, I_ADD3, 1'b1, 1'b0);
    checkOutput("reset_bundle", {9'd0, obs_bundle}, 32'd0);
    applyStimulus(1'b0, I_NOP, 1'b1, 1'b0);
    checkOutput("add_ctrl_vld", ctrl_vld_o, 1);
    checkOutput("add_rd_addr", rd_addr_o, 3);
    checkOutput("add_op_b", op_b_sel_o, 0);
    checkOutput("add_stall", stall_o, 0);

    // load-use: one stall cycle, one bubble, then the add
    applyStimulus(1'b0, I_LW5, 1'b1, 1'b0);
    applyStimulus(1'b0, I_ADD6, 1'b1, 1'b0);
    checkOutput("lu_stall", stall_o, 1);
    applyStimulus(1'b0, I_ADD6, 1'b1, 1'b0);
    checkOutput("lu_bubble", ctrl_vld_o, 0);
    checkOutput("lu_stall_drop", stall_o, 0);
    applyStimulus(1'b0, I_NOP, 1'b1, 1'b0);
    checkOutput("lu_add_rd", rd_addr_o, 6);

    // multiply
    applyStimulus(1'b0, I_MUL7, 1'b1, 1'b0);
    applyStimulus(1'b0, I_NOP, 1'b1, 1'b0);
`ifdef RV32M_EXT_EN
    checkOutput("mul_md_vld", md_vld_o, 1);
    checkOutput("mul_md_op", md_op_o, 0);
    checkOutput("mul_stall", stall_o, 1);
`else
    checkOutput("mul_illegal", illegal_o, 1);
    checkOutput("mul_stall", stall_o, 0);
`endif
    applyStimulus(1'b0, I_NOP, 1'b1, 1'b0);
    checkOutput("mul_stall_end", stall_o, 0);
    applyStimulus(1'b0, I_NOP, 1'b1, 1'b0);
    checkOutput("mul_next_md_vld", md_vld_o, 0);

    // full-length divide
    applyStimulus(1'b0, I_DIV8, 1'b1, 1'b0);
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, I_ADDI9, 1'b1, 1'b0);
      if (stall_o) stall_cnt++;
    end
`ifdef RV32M_EXT_EN
    checkOutput("div_stall_len", stall_cnt, DIV_LAT - 1);
`else
    checkOutput("div_stall_len", stall_cnt, 0);
`endif

    // divide killed by a flush in its tenth busy cycle
    applyStimulus(1'b0, I_DIV8, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, I_ADDI9, 1'b1, 1'b0);
    applyStimulus(1'b0, I_ADDI9, 1'b1, 1'b1);
    applyStimulus(1'b0, I_ADDI9, 1'b1, 1'b0);
    checkOutput("flush_bubble", ctrl_vld_o, 0);
    checkOutput("flush_stall", stall_o, 0);

    // unknown opcode
    applyStimulus(1'b0, I_BAD, 1'b1, 1'b0);
    applyStimulus(1'b0, I_NOP, 1'b1, 1'b0);
    checkOutput("bad_illegal", illegal_o, 1);
    checkOutput("bad_side_effects", {rd_wren_o, mem_wren_o, mem_rden_o}, 0);

    // reset in the middle of a divide
    applyStimulus(1'b0, I_DIV8, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, I_ADDI9, 1'b1, 1'b0);
    applyStimulus(1'b1, I_ADDI9, 1'b1, 1'b0);
    applyStimulus(1'b0, I_ADDI9, 1'b1, 1'b0);
    checkOutput("rst_bundle", {9'd0, obs_bundle}, 32'd0);
    checkOutput("rst_stall", stall_o, 0);

    // randomized traffic; the front end holds its instruction while stalled
    rnd_ins = I_NOP; rnd_vld = 1'b1;
    for (int i = 0; i < 700; i++) begin
      rnd_rst = ($urandom_range(0, 79) == 0);
      rnd_fl  = ($urandom_range(0, 29) == 0);
      if (!model_stall || rnd_rst || rnd_fl) begin
        rnd_ins = rand_instr();
        rnd_vld = ($urandom_range(0, 9) != 0);
      end
      applyStimulus(rnd_rst, rnd_ins, rnd_vld, rnd_fl);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
